friscv_cache_req_arbiter: RTL and testbench
===========================================

# friscv_cache_req_arbiter

Read-request arbiter for the data cache. It shares the single read-address path between the block fetcher (cache-line refills) and the IO fetcher (uncached accesses). Each accepted request has its ID replaced by the tag offered by the out-of-order completion manager, and the manager is told the original ID so it can reorder completions. The request is then issued through a one-entry registered stage toward the AXI4 memory interface.

## Interface
Parameters:
- AXI_ADDR_W, 8, address width
- AXI_ID_W, 8, ID/tag width
- NAME, "dCache-Req-Arb", module name used in simulation messages

Ports:
- aclk  in  1  clock; one clock domain
- srst  in  1  reset, synchronous, active-high
- next_tag  in  AXI_ID_W  tag offered by the completion manager
- tag_avlb  in  1  offered tag is free
- blk_avalid  in  1  block fetcher request valid
- blk_aready  out  1  block fetcher request accepted
- blk_addr  in  AXI_ADDR_W  block fetcher address
- blk_aid  in  AXI_ID_W  block fetcher original ID
- blk_acache  in  4  block fetcher AxCACHE
- io_avalid, io_aready, io_addr, io_aid, io_acache: same directions and widths as blk_*, for the IO fetcher
- mst_avalid  out  1  issued request valid
- mst_aready  in  1  memory accepts request
- mst_addr  out  AXI_ADDR_W  issued address
- mst_aid  out  AXI_ID_W  issued ID (substituted tag)
- mst_acache  out  4  issued AxCACHE
- trk_valid  out  1  tag consumed this cycle; drives the manager's request valid with its ready tied high
- trk_aid  out  AXI_ID_W  original ID of the request consuming the tag
- trk_acache  out  4  AxCACHE of that request; bit 1 marks IO

## Operation
- State:
  - last_grant (BLK/IO): the requester that won the most recent acceptance.
  - Output stage: out_valid plus the addr/tag/acache registers.
- Acceptance condition: acc_ok = tag_avlb && (!out_valid || mst_aready).
- Arbitration is two-way round-robin:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - The grant is combinational. It is evaluated only when acc_ok is true.
- Acceptance:
  - blk_aready = acc_ok && grant==BLK, and the same rule applies to io_aready.
  - At most one requester is accepted per cycle.
  - Readies never depend on the other requester's aready.
- On acceptance:
  - The output stage loads the requester's addr and acache, with mst_aid = next_tag.
  - out_valid is set.
  - last_grant is updated.
  - trk_valid=1 in the same cycle, with trk_aid and trk_acache taken combinationally from the granted requester.
- Drain: mst_avalid && mst_aready with no new acceptance clears out_valid. Accept-while-draining reloads the stage with no bubble.
- A held request (mst_avalid && !mst_aready) keeps mst_addr, mst_aid and mst_acache stable.
- tag_avlb=0 blocks all acceptance. A request already in the output stage still drains.
- Under FRISCV_SIM, an error is printed if trk_valid is asserted while tag_avlb=0, or if both readies are high in the same cycle.

## Timing
- Reset (srst=1 at a rising edge):
  - Outputs: out_valid=0, mst_avalid=0, mst_addr/mst_aid/mst_acache=0.
  - last_grant=IO, so BLK wins the first contention.
  - blk_aready, io_aready and trk_valid are forced to 0 while srst is high.
- Reset mid-operation: a buffered request is dropped without a handshake. The completion manager is reset by the same srst.
- Latency: requester handshake at cycle N gives mst_avalid=1 at N+1 with the captured tag.
- Throughput: one request per cycle when mst_aready=1 and tag_avlb=1 continuously.
- AXI rule: once mst_avalid is high it stays high until mst_aready.
- Simultaneous events:
  - Drain plus new accept in the same cycle gives out_valid staying 1 with new contents.
  - srst has priority over all events.
- No combinational path from mst_aready to mst_avalid. Paths from mst_aready to blk_aready/io_aready are permitted.

## Structure
- Shared package friscv_cache_pkg holds:
  - the requester enum (BLK=1'b0, IO=1'b1);
  - the AxCACHE bit index for IO (localparam ACACHE_IO_BIT=1).
- A single sub-module is natural: friscv_rr_arb2, a two-input round-robin grant unit that holds last_grant and has inputs req[1:0] and en, and output gnt[1:0].
- The output stage is inline.

## Test plan
- Single BLK request, addr=0x40, aid=0x5, next_tag=0x21, tag_avlb=1, mst_aready=1:
  - blk_aready=1 at N, with trk_valid=1 and trk_aid=0x5;
  - mst_avalid=1 at N+1 with mst_addr=0x40, mst_aid=0x21.
- Both valid continuously, mst_aready=1: grants alternate BLK, IO, BLK, IO starting with BLK after reset, and trk_acache[1] alternates 0, 1.
- mst_aready=0 for 3 cycles with one request buffered:
  - mst_* stays stable;
  - no new acceptance;
  - when mst_aready rises, the next request loads the same cycle (no bubble).
- tag_avlb=0 with both requesters valid:
  - both readies are 0 and trk_valid=0;
  - when tag_avlb rises, exactly one acceptance occurs, using next_tag.
- srst asserted while out_valid=1 and mst_aready=0:
  - next cycle mst_avalid=0 and mst_* are zero;
  - readies are 0 during reset;
  - the first post-reset contention goes to BLK.

Source files
------------

// File: rtl/friscv_cache_pkg.sv
// Shared types for the data cache request path.
// Requester identity and AxCACHE bit positions.
package friscv_cache_pkg;

    typedef enum logic {
        BLK = 1'b0,
        IO  = 1'b1
    } req_e;

    localparam int ACACHE_IO_BIT = 1;

endpackage

// File: rtl/friscv_rr_arb2.sv
// Two-input round-robin grant unit.
// Remembers the last winner; the other side wins a tie.
module friscv_rr_arb2
    import friscv_cache_pkg::*;
(
    input  logic       aclk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    req_e last_grant;

    // Combinational grant, only while the caller can accept
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == IO) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Track the most recent winner; reset favours BLK next
    always_ff @(posedge aclk) begin
        if (srst) begin
            last_grant <= IO;
        end else if (gnt[0]) begin
            last_grant <= BLK;
        end else if (gnt[1]) begin
            last_grant <= IO;
        end
    end

endmodule

// File: rtl/friscv_cache_req_arbiter.sv
// Data cache read-request arbiter: block vs IO fetcher,
// ID swapped for a completion-manager tag, one-entry output stage.
module friscv_cache_req_arbiter
    import friscv_cache_pkg::*;
#(
    parameter int AXI_ADDR_W = 8,
    parameter int AXI_ID_W   = 8,
    parameter     NAME       = "dCache-Req-Arb"
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic [AXI_ID_W-1:0]   next_tag,
    input  logic                  tag_avlb,
    input  logic                  blk_avalid,
    output logic                  blk_aready,
    input  logic [AXI_ADDR_W-1:0] blk_addr,
    input  logic [AXI_ID_W-1:0]   blk_aid,
    input  logic [3:0]            blk_acache,
    input  logic                  io_avalid,
    output logic                  io_aready,
    input  logic [AXI_ADDR_W-1:0] io_addr,
    input  logic [AXI_ID_W-1:0]   io_aid,
    input  logic [3:0]            io_acache,
    output logic                  mst_avalid,
    input  logic                  mst_aready,
    output logic [AXI_ADDR_W-1:0] mst_addr,
    output logic [AXI_ID_W-1:0]   mst_aid,
    output logic [3:0]            mst_acache,
    output logic                  trk_valid,
    output logic [AXI_ID_W-1:0]   trk_aid,
    output logic [3:0]            trk_acache
);

    logic                  out_valid;
    logic                  acc_ok;
    logic [1:0]            gnt;
    logic                  sel_io;
    logic [AXI_ADDR_W-1:0] sel_addr;

    // Accept only with a free tag and room in the stage
    assign acc_ok = !srst && tag_avlb
                    && (!out_valid || mst_aready);

    friscv_rr_arb2 u_arb (
        .aclk (aclk),
        .srst (srst),
        .req  ({io_avalid, blk_avalid}),
        .en   (acc_ok),
        .gnt  (gnt)
    );

    assign blk_aready = gnt[BLK];
    assign io_aready  = gnt[IO];
    assign trk_valid  = |gnt;

    assign sel_io     = gnt[IO];
    assign sel_addr   = sel_io ? io_addr : blk_addr;
    assign trk_aid    = sel_io ? io_aid : blk_aid;
    assign trk_acache = sel_io ? io_acache : blk_acache;

    // Output stage: load on accept, clear on drain, else hold
    always_ff @(posedge aclk) begin
        if (srst) begin
            out_valid  <= 1'b0;
            mst_addr   <= '0;
            mst_aid    <= '0;
            mst_acache <= '0;
        end else if (trk_valid) begin
            out_valid  <= 1'b1;
            mst_addr   <= sel_addr;
            mst_aid    <= next_tag;
            mst_acache <= trk_acache;
        end else if (mst_aready) begin
            out_valid  <= 1'b0;
        end
    end

    assign mst_avalid = out_valid;

`ifdef FRISCV_SIM
    // Simulation-only protocol sanity checks
    always @(posedge aclk) begin
        if (!srst && trk_valid && !tag_avlb)
            $display("%s: ERROR tag consumed while unavailable", NAME);
        if (!srst && blk_aready && io_aready)
            $display("%s: ERROR both requesters ready", NAME);
    end
`endif

endmodule

// File: tb/tb_friscv_cache_req_arbiter.sv
// Directed self-checking bench for friscv_cache_req_arbiter.
// Linear stimulus with hand-computed expectations.
module tb_friscv_cache_req_arbiter;

    logic       aclk = 1'b0;
    logic       srst;
    logic [7:0] next_tag;
    logic       tag_avlb;
    logic       blk_avalid;
    logic       blk_aready;
    logic [7:0] blk_addr;
    logic [7:0] blk_aid;
    logic [3:0] blk_acache;
    logic       io_avalid;
    logic       io_aready;
    logic [7:0] io_addr;
    logic [7:0] io_aid;
    logic [3:0] io_acache;
    logic       mst_avalid;
    logic       mst_aready;
    logic [7:0] mst_addr;
    logic [7:0] mst_aid;
    logic [3:0] mst_acache;
    logic       trk_valid;
    logic [7:0] trk_aid;
    logic [3:0] trk_acache;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    friscv_cache_req_arbiter #(
        .AXI_ADDR_W (8),
        .AXI_ID_W   (8),
        .NAME       ("dCache-Req-Arb")
    ) dut (
        .aclk       (aclk),
        .srst       (srst),
        .next_tag   (next_tag),
        .tag_avlb   (tag_avlb),
        .blk_avalid (blk_avalid),
        .blk_aready (blk_aready),
        .blk_addr   (blk_addr),
        .blk_aid    (blk_aid),
        .blk_acache (blk_acache),
        .io_avalid  (io_avalid),
        .io_aready  (io_aready),
        .io_addr    (io_addr),
        .io_aid     (io_aid),
        .io_acache  (io_acache),
        .mst_avalid (mst_avalid),
        .mst_aready (mst_aready),
        .mst_addr   (mst_addr),
        .mst_aid    (mst_aid),
        .mst_acache (mst_acache),
        .trk_valid  (trk_valid),
        .trk_aid    (trk_aid),
        .trk_acache (trk_acache)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        srst       = 1'b1;
        next_tag   = 8'h00;
        tag_avlb   = 1'b1;
        blk_avalid = 1'b1;
        blk_addr   = 8'h40;
        blk_aid    = 8'h05;
        blk_acache = 4'b0000;
        io_avalid  = 1'b1;
        io_addr    = 8'h80;
        io_aid     = 8'h09;
        io_acache  = 4'b0010;
        mst_aready = 1'b1;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_avalid", 32'(mst_avalid), 32'h0);
        chk("rst_addr", 32'(mst_addr), 32'h0);
        chk("rst_aid", 32'(mst_aid), 32'h0);
        chk("rst_blk_rdy", 32'(blk_aready), 32'h0);
        chk("rst_io_rdy", 32'(io_aready), 32'h0);
        chk("rst_trk", 32'(trk_valid), 32'h0);

        // Single BLK request
        srst      = 1'b0;
        io_avalid = 1'b0;
        next_tag  = 8'h21;
        #1;
        chk("single_blk_rdy", 32'(blk_aready), 32'h1);
        chk("single_io_rdy", 32'(io_aready), 32'h0);
        chk("single_trk", 32'(trk_valid), 32'h1);
        chk("single_trk_aid", 32'(trk_aid), 32'h05);
        chk("single_trk_cache", 32'(trk_acache), 32'h0);
        tick();
        blk_avalid = 1'b0;
        chk("single_avalid", 32'(mst_avalid), 32'h1);
        chk("single_addr", 32'(mst_addr), 32'h40);
        chk("single_aid", 32'(mst_aid), 32'h21);
        tick();
        chk("drain_avalid", 32'(mst_avalid), 32'h0);

        // Round-robin after a fresh reset
        srst = 1'b1;
        tick();
        srst       = 1'b0;
        blk_avalid = 1'b1;
        io_avalid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_tag = 8'(8'h30 + k);
            #1;
            chk("rr_blk_rdy", 32'(blk_aready), ((k % 2) == 0) ? 32'h1 : 32'h0);
            chk("rr_io_rdy", 32'(io_aready), ((k % 2) == 1) ? 32'h1 : 32'h0);
            chk("rr_trk_io", 32'(trk_acache[1]), ((k % 2) == 1) ? 32'h1 : 32'h0);
            tick();
            chk("rr_avalid", 32'(mst_avalid), 32'h1);
            chk("rr_aid", 32'(mst_aid), 32'(8'h30 + k));
            chk("rr_addr", 32'(mst_addr), ((k % 2) == 0) ? 32'h40 : 32'h80);
        end

        // Backpressure: stage holds IO request with tag 0x33
        io_avalid  = 1'b0;
        mst_aready = 1'b0;
        next_tag   = 8'h44;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_blk_rdy", 32'(blk_aready), 32'h0);
            chk("stall_trk", 32'(trk_valid), 32'h0);
            tick();
            chk("stall_avalid", 32'(mst_avalid), 32'h1);
            chk("stall_addr", 32'(mst_addr), 32'h80);
            chk("stall_aid", 32'(mst_aid), 32'h33);
            chk("stall_cache", 32'(mst_acache), 32'h2);
        end
        mst_aready = 1'b1;
        #1;
        chk("nobubble_rdy", 32'(blk_aready), 32'h1);
        tick();
        blk_avalid = 1'b0;
        chk("nobubble_avalid", 32'(mst_avalid), 32'h1);
        chk("nobubble_addr", 32'(mst_addr), 32'h40);
        chk("nobubble_aid", 32'(mst_aid), 32'h44);

        // No tag: nothing accepted, stage still drains
        tag_avlb   = 1'b0;
        blk_avalid = 1'b1;
        io_avalid  = 1'b1;
        #1;
        chk("notag_blk_rdy", 32'(blk_aready), 32'h0);
        chk("notag_io_rdy", 32'(io_aready), 32'h0);
        chk("notag_trk", 32'(trk_valid), 32'h0);
        tick();
        chk("notag_drain", 32'(mst_avalid), 32'h0);
        tag_avlb = 1'b1;
        next_tag = 8'h55;
        #1;
        chk("tag_io_rdy", 32'(io_aready), 32'h1);
        chk("tag_blk_rdy", 32'(blk_aready), 32'h0);
        chk("tag_trk_aid", 32'(trk_aid), 32'h09);
        tick();
        blk_avalid = 1'b0;
        io_avalid  = 1'b0;
        chk("tag_aid", 32'(mst_aid), 32'h55);
        chk("tag_addr", 32'(mst_addr), 32'h80);

        // Reset with a request held in the stage
        mst_aready = 1'b0;
        srst       = 1'b1;
        blk_avalid = 1'b1;
        io_avalid  = 1'b1;
        #1;
        chk("midrst_blk_rdy", 32'(blk_aready), 32'h0);
        chk("midrst_io_rdy", 32'(io_aready), 32'h0);
        chk("midrst_trk", 32'(trk_valid), 32'h0);
        tick();
        chk("midrst_avalid", 32'(mst_avalid), 32'h0);
        chk("midrst_addr", 32'(mst_addr), 32'h0);
        chk("midrst_aid", 32'(mst_aid), 32'h0);
        chk("midrst_cache", 32'(mst_acache), 32'h0);
        srst       = 1'b0;
        mst_aready = 1'b1;
        #1;
        chk("post_blk_rdy", 32'(blk_aready), 32'h1);
        chk("post_io_rdy", 32'(io_aready), 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
